// File: rtl/rf_param_dump.sv
// DEPTH x DATA_W register file with two registered read ports, one write port, and a halt-time dump engine.
// Define RF_BYPASS_EN for write-through forwarding on the read ports (dump path is never bypassed).
module rf_param_dump #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              re0,
    input  logic              re1,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] dst,
    input  logic              we,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_vld,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] rd0, rd1, dump_rd;
    logic              we_eff;

    assign we_eff = we && !((ZERO_REG != 0) && (dst_addr == '0));

    // NOTE: every entry is reset explicitly, so the array is built from flops and clears with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we_eff) begin
            // NOTE: non-blocking assignment keeps reads and the dump on the pre-write value this edge.
            mem[dst_addr] <= dst;
        end
    end

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        rd0     = mem[p0_addr];
        rd1     = mem[p1_addr];
        dump_rd = mem[idx];
`ifdef RF_BYPASS_EN
        if (we_eff && (p0_addr == dst_addr)) rd0 = dst;
        if (we_eff && (p1_addr == dst_addr)) rd1 = dst;
`endif
        if ((ZERO_REG != 0) && (p0_addr == '0)) rd0 = '0;
        if ((ZERO_REG != 0) && (p1_addr == '0)) rd1 = '0;
        if ((ZERO_REG != 0) && (idx == '0))     dump_rd = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            if (re0) p0 <= rd0;
            if (re1) p1 <= rd1;
        end
    end

    // Dump FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Dump FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (dump_req) state_nxt = SCAN;
            SCAN:    if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Dump FSM: outputs
    always_comb begin
        dump_busy = (state == SCAN) || (state == DONE);
    end

    // Registered dump stream; addr/data hold their last value once the scan ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            dump_vld  <= 1'b0;
            dump_done <= 1'b0;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    dump_vld  <= 1'b0;
                    dump_done <= 1'b0;
                    if (dump_req) idx <= START;
                end
                SCAN: begin
                    dump_vld  <= 1'b1;
                    dump_addr <= idx;
                    dump_data <= dump_rd;
                    idx       <= idx + ADDR_W'(1);
                end
                DONE: begin
                    dump_vld  <= 1'b0;
                    dump_done <= 1'b1;
                end
                default: begin
                    dump_vld  <= 1'b0;
                    dump_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_param_dump.sv
// Randomized bench for rf_param_dump against a cycle-indexed reference model of the register file and dump stream.
// Honours RF_BYPASS_EN the same way the design does.
module tb_rf_param_dump;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int ZR    = 1;
    localparam int S     = (ZR != 0) ? 1 : 0;
    localparam int NDUMP = DEPTH - S;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] p0_addr, p1_addr, dst_addr;
    logic          re0, re1, we, dump_req;
    logic [DW-1:0] dst, p0, p1, dump_data;
    logic          dump_busy, dump_vld, dump_done;
    logic [AW-1:0] dump_addr;

    rf_param_dump #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .p0(p0), .p1(p1),
        .dst_addr(dst_addr), .dst(dst), .we(we),
        .dump_req(dump_req), .dump_busy(dump_busy), .dump_vld(dump_vld),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: contents, read registers, and the edge at which the current dump was accepted.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_p0, m_p1, m_ddata;
    logic [AW-1:0] m_daddr;
    int            edge_n, t0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (ZR != 0 && a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (we && !(ZR != 0 && dst_addr == 0) && a == dst_addr) return dst;
`endif
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_p0 = '0; m_p1 = '0; m_daddr = '0; m_ddata = '0;
        edge_n = 0; t0 = -1;
    endtask

    task automatic model_edge();
        int k;
        edge_n++;
        k = (t0 < 0) ? -1 : edge_n - t0;
        if (k >= 1 && k <= NDUMP) begin
            m_daddr = AW'(S + k - 1);
            m_ddata = m_mem[S + k - 1];
        end
        if (re0) m_p0 = model_read(p0_addr);
        if (re1) m_p1 = model_read(p1_addr);
        if (dump_req && (t0 < 0 || k >= NDUMP + 2)) t0 = edge_n;
        if (we && !(ZR != 0 && dst_addr == 0)) m_mem[dst_addr] = dst;
    endtask

    task automatic compare_all();
        int k;
        k = (t0 < 0) ? -1 : edge_n - t0;
        check("p0", p0, m_p0);
        check("p1", p1, m_p1);
        check("dump_vld",  dump_vld,  (k >= 1 && k <= NDUMP) ? 1 : 0);
        check("dump_done", dump_done, (k == NDUMP + 1) ? 1 : 0);
        check("dump_busy", dump_busy, (k >= 0 && k <= NDUMP) ? 1 : 0);
        check("dump_addr", dump_addr, m_daddr);
        check("dump_data", dump_data, m_ddata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        re0 = 0; re1 = 0; we = 0; dump_req = 0;
        p0_addr = '0; p1_addr = '0; dst_addr = '0; dst = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int vcnt, dcnt;
        bit found;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Read after reset
        re0 = 1; p0_addr = 4'd5;
        tick();
        check("reset_read_p0", p0, 16'h0000);

        // Write then read, then hold
        re0 = 0; we = 1; dst_addr = 4'd3; dst = 16'hBEEF;
        tick();
        we = 0; re0 = 1; p0_addr = 4'd3;
        tick();
        check("read_beef", p0, 16'hBEEF);
        re0 = 0; p0_addr = 4'd9;
        tick(); tick();
        check("hold_beef", p0, 16'hBEEF);

        // Entry 0 ignores writes
        we = 1; dst_addr = 4'd0; dst = 16'h1234;
        tick();
        we = 0; re0 = 1; re1 = 1; p0_addr = 4'd0; p1_addr = 4'd0;
        tick();
        check("zero_p0", p0, 16'h0000);
        check("zero_p1", p1, 16'h0000);

        // Same-edge write and read
        re0 = 0; re1 = 0; we = 1; dst_addr = 4'd7; dst = 16'h1111;
        tick();
        dst = 16'hA5A5; re1 = 1; p1_addr = 4'd7;
        tick();
`ifdef RF_BYPASS_EN
        check("same_edge_p1", p1, 16'hA5A5);
`else
        check("same_edge_p1", p1, 16'h1111);
`endif
        idle_inputs();

        // Load ramp, full dump, ignored mid-scan request
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; dst_addr = AW'(i); dst = DW'(i * 16'h0101);
            tick();
        end
        we = 0; dump_req = 1;
        tick();
        dump_req = 0;
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            dump_req = (c == 5);
            tick();
            if (dump_vld) begin
                check("dump_seq_addr", dump_addr, 1 + vcnt);
                check("dump_seq_data", dump_data, (1 + vcnt) * 32'h0101);
                vcnt++;
            end
            if (dump_done) dcnt++;
        end
        dump_req = 0;
        check("dump_vld_count", vcnt, NDUMP);
        check("dump_done_count", dcnt, 1);

        // Reset in the middle of a dump, then restart
        dump_req = 1;
        tick();
        dump_req = 0;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (dump_vld && dump_addr == 4'd6) found = 1;
        end
        check("wait_addr6", found, 1);
        apply_reset();
        check("rst_vld", dump_vld, 0);
        check("rst_done", dump_done, 0);
        check("rst_busy", dump_busy, 0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (dump_done) dcnt++;
        end
        check("rst_no_done", dcnt, 0);
        dump_req = 1;
        tick();
        dump_req = 0;
        tick();
        check("restart_vld", dump_vld, 1);
        check("restart_addr", dump_addr, 1);

        // Random traffic, including requests while busy and rare resets
        for (int c = 0; c < 1500; c++) begin
            we       = 1'($urandom);
            re0      = 1'($urandom);
            re1      = 1'($urandom);
            dst      = DW'($urandom);
            dst_addr = AW'($urandom);
            p0_addr  = ($urandom_range(0, 3) == 0) ? dst_addr : AW'($urandom);
            p1_addr  = ($urandom_range(0, 3) == 0) ? p0_addr  : AW'($urandom);
            dump_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) apply_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
